// File: rtl/dma_channel_arbiter_if.sv
// Handshake/bus bundle between the DMA channel arbiter and its surroundings.
// Latency: none (wires only).
// Backpressure: none; HRQ/HLDA is the only handshake, and the arbiter owns it.
// Optional feature macro: DMA_SOFT_REQ_EN adds the swReqClr return path.
interface dma_channel_arbiter_if;
    logic [3:0] DREQ;
    logic       dreqSenseHigh;
    logic       dackSenseHigh;
    logic       priorityType;
    logic       ctrlDisable;
    logic [3:0] maskReg;
    logic [3:0] swRequest;
    logic       HLDA;
    logic       serviceDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantChannel;
    logic [7:0] priorityOrder;
`ifdef DMA_SOFT_REQ_EN
    logic [3:0] swReqClr;
`endif

    // Arbiter side: consumes requests/command bits, drives handshake and grant.
    modport master (
        input  DREQ, dreqSenseHigh, dackSenseHigh, priorityType, ctrlDisable,
        input  maskReg, swRequest, HLDA, serviceDone,
`ifdef DMA_SOFT_REQ_EN
        output swReqClr,
`endif
        output HRQ, DACK, grantValid, grantChannel, priorityOrder
    );

    // Environment side: pins, command register, CPU and timing control.
    modport slave (
        output DREQ, dreqSenseHigh, dackSenseHigh, priorityType, ctrlDisable,
        output maskReg, swRequest, HLDA, serviceDone,
`ifdef DMA_SOFT_REQ_EN
        input  swReqClr,
`endif
        input  HRQ, DACK, grantValid, grantChannel, priorityOrder
    );
endinterface

// File: rtl/dma_channel_arbiter.sv
// 4-channel DMA request/priority arbiter with HRQ/HLDA handshake (fixed or rotating priority).
// Latency: DREQ registered once; every output is registered, so a decision in cycle N shows at N+1.
// Backpressure: no grant until HLDA; an HLDA drop during GRANT aborts at once. Macro DMA_SOFT_REQ_EN enables software requests.
module dma_channel_arbiter #(
    parameter int         NUM_CH    = 4,
    parameter logic [7:0] ORDER_RST = 8'b11_10_01_00
) (
    input  logic               CLK,
    input  logic               RESET_N,
    dma_channel_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

    state_t     state, state_nxt;
    logic [3:0] dreq_q;
    logic [3:0] eff_req;
    logic [1:0] win_ch;
    logic [3:0] dack_idle;
    logic [7:0] order_rot;

    logic       hrq_q,   hrq_nxt;
    logic       gv_q,    gv_nxt;
    logic [1:0] gch_q,   gch_nxt;
    logic [3:0] dack_q,  dack_nxt;
    logic [7:0] order_q, order_nxt;
`ifdef DMA_SOFT_REQ_EN
    logic [3:0] clr_q,   clr_nxt;
`endif

    // Raw pins are polarity-corrected and masked; software requests bypass both.
`ifdef DMA_SOFT_REQ_EN
    assign eff_req = ((dreq_q ^ {4{~bus.dreqSenseHigh}}) & ~bus.maskReg) | bus.swRequest;
`else
    logic unused_sw;
    assign unused_sw = ^bus.swRequest;
    assign eff_req   = (dreq_q ^ {4{~bus.dreqSenseHigh}}) & ~bus.maskReg;
`endif

    assign dack_idle = {4{~bus.dackSenseHigh}};
    // Serviced channel k drops to lowest priority, k+1 becomes highest.
    assign order_rot = {gch_q, gch_q + 2'd3, gch_q + 2'd2, gch_q + 2'd1};

    // Winner: scan priority slots from lowest to highest so the highest-priority requester wins last.
    always_comb begin
        win_ch = order_q[1:0];
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eff_req[order_q[2*i +: 2]]) begin
                win_ch = order_q[2*i +: 2];
            end
        end
    end

    // Next-state and next-output decode for the handshake FSM.
    always_comb begin
        state_nxt = state;
        hrq_nxt   = hrq_q;
        gv_nxt    = gv_q;
        gch_nxt   = gch_q;
        dack_nxt  = dack_q;
        order_nxt = order_q;
`ifdef DMA_SOFT_REQ_EN
        clr_nxt   = 4'b0000;
`endif
        case (state)
            IDLE: begin
                hrq_nxt  = 1'b0;
                gv_nxt   = 1'b0;
                dack_nxt = dack_idle;
                if (!bus.priorityType) begin
                    order_nxt = ORDER_RST;
                end
                if (|eff_req && !bus.ctrlDisable) begin
                    state_nxt = REQ;
                    hrq_nxt   = 1'b1;
                end
            end
            REQ: begin
                dack_nxt = dack_idle;
                if (bus.HLDA && |eff_req) begin
                    state_nxt = GRANT;
                    gch_nxt   = win_ch;
                    gv_nxt    = 1'b1;
                    dack_nxt  = dack_idle ^ (4'b0001 << win_ch);
                end else if (!(|eff_req)) begin
                    state_nxt = IDLE;
                    hrq_nxt   = 1'b0;
                end
            end
            GRANT: begin
                // CPU abort takes precedence over a normal end of service.
                if (!bus.HLDA) begin
                    state_nxt = IDLE;
                    hrq_nxt   = 1'b0;
                    gv_nxt    = 1'b0;
                    dack_nxt  = dack_idle;
                end else if (bus.serviceDone) begin
                    state_nxt = RELEASE;
                    hrq_nxt   = 1'b0;
                    gv_nxt    = 1'b0;
                    dack_nxt  = dack_idle;
`ifdef DMA_SOFT_REQ_EN
                    if (bus.swRequest[gch_q]) begin
                        clr_nxt = 4'b0001 << gch_q;
                    end
`endif
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
                hrq_nxt   = 1'b0;
                gv_nxt    = 1'b0;
                dack_nxt  = dack_idle;
                if (bus.priorityType) begin
                    order_nxt = order_rot;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, input sync and registered outputs; all clear asynchronously on reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            dreq_q  <= 4'b0000;
            hrq_q   <= 1'b0;
            gv_q    <= 1'b0;
            gch_q   <= 2'b00;
            dack_q  <= 4'b0000;
            order_q <= ORDER_RST;
`ifdef DMA_SOFT_REQ_EN
            clr_q   <= 4'b0000;
`endif
        end else begin
            state   <= state_nxt;
            dreq_q  <= bus.DREQ;
            hrq_q   <= hrq_nxt;
            gv_q    <= gv_nxt;
            gch_q   <= gch_nxt;
            dack_q  <= dack_nxt;
            order_q <= order_nxt;
`ifdef DMA_SOFT_REQ_EN
            clr_q   <= clr_nxt;
`endif
        end
    end

    assign bus.HRQ           = hrq_q;
    assign bus.grantValid    = gv_q;
    assign bus.grantChannel  = gch_q;
    assign bus.DACK          = dack_q;
    assign bus.priorityOrder = order_q;
`ifdef DMA_SOFT_REQ_EN
    assign bus.swReqClr      = clr_q;
`endif

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter; grants are scoreboarded against a queue of expected channel/DACK pairs.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: HLDA driven directly by the stimulus sequence.
module tb_dma_channel_arbiter;

    localparam logic [7:0] ORDER_RST = 8'b11_10_01_00;

    typedef struct {
        logic [1:0] ch;
        logic [3:0] dack;
    } grant_t;

    logic   clk = 1'b0;
    logic   rst_n;
    int     n_checks = 0;
    int     n_pass   = 0;
    grant_t exp_q[$];
    logic   gv_prev  = 1'b0;
    int     bad_cycles;

    dma_channel_arbiter_if bus();

    dma_channel_arbiter #(.NUM_CH(4), .ORDER_RST(ORDER_RST)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_grant(input logic [1:0] ch, input logic [3:0] dack);
        grant_t g;
        g.ch   = ch;
        g.dack = dack;
        exp_q.push_back(g);
    endtask

    task automatic wait_grant(input string tag, input int max_cycles);
        int n = 0;
        while (bus.grantValid !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus.grantValid, 1'b1);
    endtask

    task automatic service();
        bus.serviceDone = 1'b1;
        tick(1);
        bus.serviceDone = 1'b0;
        tick(1);
    endtask

    // Scoreboard: each new grant must match the oldest expected grant.
    always @(negedge clk) begin
        if (bus.grantValid === 1'b1 && gv_prev !== 1'b1) begin
            chk("grant_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
                grant_t g;
                g = exp_q.pop_front();
                chk("sb_channel", bus.grantChannel, g.ch);
                chk("sb_dack", bus.DACK, g.dack);
            end
        end
        gv_prev = bus.grantValid;
    end

    initial begin
        rst_n             = 1'b1;
        bus.DREQ          = 4'b0000;
        bus.dreqSenseHigh = 1'b1;
        bus.dackSenseHigh = 1'b1;
        bus.priorityType  = 1'b0;
        bus.ctrlDisable   = 1'b0;
        bus.maskReg       = 4'b0000;
        bus.swRequest     = 4'b0000;
        bus.HLDA          = 1'b0;
        bus.serviceDone   = 1'b0;
        #1 rst_n = 1'b0;
        tick(1);
        chk("rst_hrq", bus.HRQ, 1'b0);
        chk("rst_dack", bus.DACK, 4'b0000);
        chk("rst_gv", bus.grantValid, 1'b0);
        chk("rst_gch", bus.grantChannel, 2'b00);
        chk("rst_order", bus.priorityOrder, ORDER_RST);
        rst_n = 1'b1;
        tick(1);

        // Fixed mode, two requesters, HLDA already high: channel 1 wins.
        bus.HLDA = 1'b1;
        bus.DREQ = 4'b0110;
        tick(1);
        chk("t1_hrq_after1", bus.HRQ, 1'b0);
        tick(1);
        chk("t1_hrq_after2", bus.HRQ, 1'b1);
        chk("t1_gv_before", bus.grantValid, 1'b0);
        push_grant(2'd1, 4'b0010);
        tick(1);
        chk("t1_dack", bus.DACK, 4'b0010);
        chk("t1_gch", bus.grantChannel, 2'd1);
        chk("t1_order", bus.priorityOrder, ORDER_RST);
        bus.DREQ = 4'b0000;
        bus.serviceDone = 1'b1;
        tick(1);
        bus.serviceDone = 1'b0;
        chk("t1_rel_hrq", bus.HRQ, 1'b0);
        chk("t1_rel_gv", bus.grantValid, 1'b0);
        chk("t1_rel_dack", bus.DACK, 4'b0000);
        tick(2);

        // Rotating mode, all requesting: grants walk 0,1,2,3,0.
        bus.priorityType = 1'b1;
        bus.DREQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] ch;
            ch = 2'(i % 4);
            push_grant(ch, 4'b0001 << ch);
            wait_grant("t2_grant_timeout", 10);
            if (i == 4) bus.DREQ = 4'b0000;
            service();
            tick(1);
            if (i == 0) chk("t2_order_after0", bus.priorityOrder, 8'b00_11_10_01);
        end
        tick(2);

        // Abort mid-GRANT on channel 2, with a coincident serviceDone: no rotation.
        bus.DREQ = 4'b0100;
        push_grant(2'd2, 4'b0100);
        wait_grant("t4_grant_timeout", 10);
        bus.HLDA = 1'b0;
        bus.serviceDone = 1'b1;
        bus.DREQ = 4'b0000;
        tick(1);
        bus.serviceDone = 1'b0;
        chk("t4_dack", bus.DACK, 4'b0000);
        chk("t4_hrq", bus.HRQ, 1'b0);
        chk("t4_gv", bus.grantValid, 1'b0);
        bus.HLDA = 1'b1;
        tick(3);
        chk("t4_order", bus.priorityOrder, 8'b00_11_10_01);

        // Fixed mode forces the order back; a masked request never raises HRQ.
        bus.priorityType = 1'b0;
        bus.maskReg = 4'b0001;
        bus.DREQ = 4'b0001;
        tick(1);
        chk("t3_order_forced", bus.priorityOrder, ORDER_RST);
        bad_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.HRQ !== 1'b0 || bus.DACK !== 4'b0000) bad_cycles++;
        end
        chk("t3_masked_bad_cycles", bad_cycles, 0);
        bus.maskReg = 4'b0000;
        push_grant(2'd0, 4'b0001);
        wait_grant("t3_grant_timeout", 10);
        chk("t3_dack", bus.DACK, 4'b0001);
        // Masking the granted channel and disabling mid-GRANT leaves the grant alone.
        bus.maskReg = 4'b0001;
        bus.ctrlDisable = 1'b1;
        tick(3);
        chk("t3_hold_gv", bus.grantValid, 1'b1);
        chk("t3_hold_dack", bus.DACK, 4'b0001);
        bus.maskReg = 4'b0000;
        service();
        tick(4);
        chk("t3_disabled_hrq", bus.HRQ, 1'b0);
        bus.DREQ = 4'b0000;
        bus.ctrlDisable = 1'b0;
        tick(2);

        // Active-low sense on both sides: DREQ=1011 asserts channel 2 only.
        bus.maskReg = 4'b1111;
        bus.DREQ = 4'b1111;
        bus.dreqSenseHigh = 1'b0;
        bus.dackSenseHigh = 1'b0;
        tick(3);
        chk("t5_idle_dack", bus.DACK, 4'b1111);
        bus.DREQ = 4'b1011;
        tick(2);
        bus.maskReg = 4'b0000;
        push_grant(2'd2, 4'b1011);
        wait_grant("t5_grant_timeout", 10);
        bus.DREQ = 4'b1111;
        service();
        chk("t5_release_dack", bus.DACK, 4'b1111);
        bus.maskReg = 4'b1111;
        bus.dreqSenseHigh = 1'b1;
        bus.dackSenseHigh = 1'b1;
        bus.DREQ = 4'b0000;
        tick(3);
        bus.maskReg = 4'b0000;

`ifdef DMA_SOFT_REQ_EN
        // Software request ignores the mask; its bit is cleared by a pulse in RELEASE.
        bus.maskReg = 4'b1111;
        bus.swRequest = 4'b1000;
        push_grant(2'd3, 4'b1000);
        wait_grant("t6_grant_timeout", 10);
        bus.serviceDone = 1'b1;
        tick(1);
        bus.serviceDone = 1'b0;
        chk("t6_clr_pulse", bus.swReqClr, 4'b1000);
        bus.swRequest = 4'b0000;
        tick(1);
        chk("t6_clr_end", bus.swReqClr, 4'b0000);
        bus.maskReg = 4'b0000;
        tick(2);
`endif

        // Asynchronous reset in the middle of a grant with a rotated order.
        bus.priorityType = 1'b1;
        bus.DREQ = 4'b0001;
        push_grant(2'd0, 4'b0001);
        push_grant(2'd0, 4'b0001);
        wait_grant("t7_grant1_timeout", 10);
        service();
        wait_grant("t7_grant2_timeout", 10);
        chk("t7_order_rotated", bus.priorityOrder, 8'b00_11_10_01);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_arst_hrq", bus.HRQ, 1'b0);
        chk("t7_arst_dack", bus.DACK, 4'b0000);
        chk("t7_arst_gv", bus.grantValid, 1'b0);
        chk("t7_arst_gch", bus.grantChannel, 2'b00);
        chk("t7_arst_order", bus.priorityOrder, ORDER_RST);
        tick(1);
        chk("sb_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
